// File: rtl/bus_gate_arbiter_pkg.sv
// Shared types and constants for the CPU bus gate arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: bus source enum, arbiter FSM state enum, source count and idle gate value.
package bus_arb_pkg;

   localparam int N_SRC = 4;

   // Bit index of each bus source within req/grant.
   typedef enum logic [1:0] {
      SRC_PC     = 2'd0,
      SRC_MDR    = 2'd1,
      SRC_ALU    = 2'd2,
      SRC_MARMUX = 2'd3
   } bus_src_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } arb_state_e;

   // All-zero gate select: no source drives the bus, mux outputs 16'h0.
   localparam logic [N_SRC-1:0] GATE_NONE = '0;

endpackage

// File: rtl/bus_gate_arbiter_if.sv
// Request/grant bundle between the bus sources and the gate arbiter.
// Latency: n/a (wiring only).
// Backpressure: none; req is a level held for the whole tenure.
// Signals: req (sources -> arbiter), grant / bus_busy / owner_id / timeout (arbiter -> sources, mux).
// Modports: master = arbiter side, slave = source / bus-mux side.
interface bus_gate_arbiter_if #(
   parameter int N_REQ = 4
);
   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] grant;
   logic             bus_busy;
   logic [IW-1:0]    owner_id;
   logic             timeout;

   modport master (
      input  req,
      output grant,
      output bus_busy,
      output owner_id,
      output timeout
   );

   modport slave (
      output req,
      input  grant,
      input  bus_busy,
      input  owner_id,
      input  timeout
   );

endinterface

// File: rtl/bus_gate_arbiter_picker.sv
// Rotating priority picker: first set request at or after ptr, wrapping.
// Latency: combinational.
// Backpressure: none.
// Ports: req (candidates), ptr (start index; tie to 0 for fixed lowest-index priority),
//        onehot / index (winner), valid (any candidate present).
module rr_priority_picker #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] index,
   output logic          valid
);

   logic [IW-1:0] j;

   always_comb begin
      onehot = '0;
      index  = '0;
      valid  = 1'b0;
      j      = '0;
      for (int k = 0; k < N; k++) begin
         // Reduce modulo N before truncating so non-power-of-two N wraps correctly.
         j = IW'((int'(ptr) + k) % N);
         if (!valid && req[j]) begin
            valid     = 1'b1;
            index     = j;
            onehot[j] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_gate_arbiter.sv
// Grants ownership of the shared 16-bit CPU bus (PC, MDR, ALU, MARMUX) as a one-hot gate select.
// Latency: req -> grant 1 cycle from idle; release -> next grant 2 edges (one dead turnaround cycle).
// Backpressure: none; an owner keeps the bus while req stays high, up to MAX_HOLD cycles (watchdog).
// Ports: Clk, Reset (sync, active-high); bus.master: req in, grant / bus_busy / owner_id / timeout out.
// Config macro BUS_ARB_ROUND_ROBIN_EN: defined = round-robin winner selection, undefined = fixed priority
// (lowest index wins). Parameter MAX_HOLD = 0 disables the watchdog.
module bus_gate_arbiter
   import bus_arb_pkg::*;
#(
   parameter int N_REQ    = N_SRC,
   parameter int MAX_HOLD = 15
) (
   input  logic              Clk,
   input  logic              Reset,
   bus_gate_arbiter_if.master bus
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

   arb_state_e       state, state_n;
   logic [N_REQ-1:0] grant_q, grant_n;
   logic             busy_q;
   logic [IW-1:0]    owner_q, owner_n;
   logic             timeout_q, timeout_n;
   logic [HW-1:0]    hold_cnt, hold_n;
   logic [N_REQ-1:0] tmask, tmask_n;
   logic [IW-1:0]    rr_ptr, rr_n;

   logic [N_REQ-1:0] elig;
   logic [N_REQ-1:0] pick_oh;
   logic [IW-1:0]    pick_idx;
   logic             pick_vld;

   // A source that was just forcibly released steps aside for one arbitration,
   // unless it is the only one asking.
   always_comb begin
      elig = bus.req & ~tmask;
      if (elig == '0) elig = bus.req;
   end

   rr_priority_picker #(.N(N_REQ), .IW(IW)) u_picker (
      .req    (elig),
      .ptr    (rr_ptr),
      .onehot (pick_oh),
      .index  (pick_idx),
      .valid  (pick_vld)
   );

   always_comb begin
      state_n   = state;
      grant_n   = grant_q;
      owner_n   = owner_q;
      timeout_n = 1'b0;
      hold_n    = hold_cnt;
      tmask_n   = tmask;
      rr_n      = rr_ptr;

      case (state)
         IDLE, GAP: begin
            if (pick_vld) begin
               state_n = GRANT;
               grant_n = pick_oh;
               owner_n = pick_idx;
               hold_n  = HW'(1);
               tmask_n = '0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
               rr_n    = IW'((int'(pick_idx) + 1) % N_REQ);
`else
               rr_n    = '0;
`endif
            end else begin
               state_n = IDLE;
               grant_n = GATE_NONE;
            end
         end
         GRANT: begin
            if (!bus.req[owner_q]) begin
               state_n = GAP;
               grant_n = GATE_NONE;
            end else if ((MAX_HOLD != 0) && (hold_cnt == HW'(MAX_HOLD))) begin
               state_n   = GAP;
               grant_n   = GATE_NONE;
               timeout_n = 1'b1;
               // grant is one-hot of the owner here, so it doubles as the mask.
               tmask_n   = grant_q;
            end else begin
               // Saturate rather than wrap when the watchdog is disabled.
               hold_n = (hold_cnt == '1) ? hold_cnt : hold_cnt + HW'(1);
            end
         end
         default: begin
            state_n = IDLE;
            grant_n = GATE_NONE;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= IDLE;
         grant_q   <= GATE_NONE;
         busy_q    <= 1'b0;
         owner_q   <= '0;
         timeout_q <= 1'b0;
         hold_cnt  <= '0;
         tmask     <= '0;
         rr_ptr    <= '0;
      end else begin
         state     <= state_n;
         grant_q   <= grant_n;
         busy_q    <= |grant_n;
         owner_q   <= owner_n;
         timeout_q <= timeout_n;
         hold_cnt  <= hold_n;
         tmask     <= tmask_n;
         rr_ptr    <= rr_n;
      end
   end

   assign bus.grant    = grant_q;
   assign bus.bus_busy = busy_q;
   assign bus.owner_id = owner_q;
   assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_bus_gate_arbiter.sv
// Self-checking bench for bus_gate_arbiter (MAX_HOLD=4): directed scenarios plus random soak.
// Each step pushes the predicted registered outputs to a queue; they are popped and compared
// half a cycle after the clock edge.
module tb_bus_gate_arbiter;
   import bus_arb_pkg::*;

   localparam int MAXH = 4;

   logic clk;
   logic rst;

   bus_gate_arbiter_if #(.N_REQ(4)) bif ();

   bus_gate_arbiter #(.N_REQ(4), .MAX_HOLD(MAXH)) dut (
      .Clk   (clk),
      .Reset (rst),
      .bus   (bif)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic [3:0] g;
      logic       b;
      logic [1:0] o;
      logic       t;
   } exp_t;

   exp_t exp_q[$];

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   int         m_state;   // 0 idle, 1 grant, 2 gap
   logic [3:0] m_grant;
   logic [1:0] m_owner;
   logic       m_tout;
   int         m_hold;
   int         m_rr;
   logic [3:0] m_tmask;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge(input logic [3:0] r, input logic rs);
      logic [3:0] el;
      int         w;
      if (rs) begin
         m_state = 0; m_grant = 4'b0; m_owner = 2'd0; m_tout = 1'b0;
         m_hold = 0; m_rr = 0; m_tmask = 4'b0;
         return;
      end
      m_tout = 1'b0;
      if (m_state == 1) begin
         if (r[m_owner] == 1'b0) begin
            m_state = 2; m_grant = 4'b0;
         end else if (m_hold == MAXH) begin
            m_state = 2; m_tmask = m_grant; m_grant = 4'b0; m_tout = 1'b1;
         end else begin
            m_hold = m_hold + 1;
         end
      end else begin
         el = ((r & ~m_tmask) != 4'b0) ? (r & ~m_tmask) : r;
         w = -1;
`ifdef BUS_ARB_ROUND_ROBIN_EN
         for (int k = 0; k < 4; k++)
            if (w < 0 && el[(m_rr + k) % 4]) w = (m_rr + k) % 4;
`else
         for (int k = 3; k >= 0; k--)
            if (el[k]) w = k;
`endif
         if (w >= 0) begin
            m_state = 1; m_grant = 4'b0001 << w; m_owner = 2'(w);
            m_hold = 1; m_tmask = 4'b0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
            m_rr = (w + 1) % 4;
`endif
         end else begin
            m_state = 0; m_grant = 4'b0;
         end
      end
   endtask

   // Drive inputs for one cycle, predict, then compare after the edge.
   task automatic step(input logic [3:0] r, input logic rs);
      exp_t e;
      bif.req = r;
      rst     = rs;
      model_edge(r, rs);
      exp_q.push_back({m_grant, |m_grant, m_owner, m_tout});
      @(posedge clk);
      @(negedge clk);
      if (exp_q.size() == 0) begin
         check_eq("queue_empty", 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         check_eq("grant",    32'(bif.grant),    32'(e.g));
         check_eq("bus_busy", 32'(bif.bus_busy), 32'(e.b));
         check_eq("owner_id", 32'(bif.owner_id), 32'(e.o));
         check_eq("timeout",  32'(bif.timeout),  32'(e.t));
         check_eq("onehot0",  32'($onehot0(bif.grant)), 32'd1);
      end
   endtask

   logic [3:0] seq [5];
   logic [3:0] g;
   logic [3:0] r;

   initial begin
      rst     = 1'b1;
      bif.req = 4'b0;

      // 1: reset with all requests held for two cycles
      step(4'b1111, 1'b1);
      step(4'b1111, 1'b1);
      check_eq("t1_grant",   32'(bif.grant),    32'h0);
      check_eq("t1_busy",    32'(bif.bus_busy), 32'h0);
      check_eq("t1_timeout", 32'(bif.timeout),  32'h0);
      check_eq("t1_owner",   32'(bif.owner_id), 32'h0);
      step(4'b1111, 1'b0);
      check_eq("t1_first",   32'(bif.grant),    32'b0001);

      // 2: single ALU request, voluntary release, back to idle
      step(4'b0000, 1'b1);
      step(4'b0100, 1'b0);
      check_eq("t2_grant", 32'(bif.grant),    32'b0100);
      check_eq("t2_owner", 32'(bif.owner_id), 32'd2);
      step(4'b0100, 1'b0);
      step(4'b0100, 1'b0);
      step(4'b0000, 1'b0);
      check_eq("t2_rel",   32'(bif.grant),    32'h0);
      check_eq("t2_gap",   32'(dut.state),    32'(GAP));
      step(4'b0000, 1'b0);
      check_eq("t2_idle",  32'(dut.state),    32'(IDLE));
      check_eq("t2_hold_owner", 32'(bif.owner_id), 32'd2);

      // 3: MDR and MARMUX, MDR wins, releases, MARMUX follows after a dead cycle
      step(4'b0000, 1'b1);
      step(4'b1010, 1'b0);
      check_eq("t3_grant", 32'(bif.grant), 32'b0010);
      step(4'b1000, 1'b0);
      check_eq("t3_gap",   32'(bif.grant), 32'b0000);
      step(4'b1000, 1'b0);
      check_eq("t3_next",  32'(bif.grant), 32'b1000);
      check_eq("t3_owner", 32'(bif.owner_id), 32'd3);

      // 4: all request; each owner drops for one cycle after two grant cycles
      step(4'b0000, 1'b1);
      step(4'b1111, 1'b0);
      seq[0] = bif.grant;
      for (int i = 1; i < 5; i++) begin
         g = bif.grant;
         step(4'b1111, 1'b0);
         step(4'b1111 & ~g, 1'b0);
         step(4'b1111, 1'b0);
         seq[i] = bif.grant;
      end
`ifdef BUS_ARB_ROUND_ROBIN_EN
      check_eq("t4_ord0", 32'(seq[0]), 32'b0001);
      check_eq("t4_ord1", 32'(seq[1]), 32'b0010);
      check_eq("t4_ord2", 32'(seq[2]), 32'b0100);
      check_eq("t4_ord3", 32'(seq[3]), 32'b1000);
      check_eq("t4_ord4", 32'(seq[4]), 32'b0001);
`else
      for (int i = 0; i < 5; i++) check_eq("t4_fixed", 32'(seq[i]), 32'b0001);
`endif

      // 5: watchdog with a competitor, then with a sole requester
      step(4'b0000, 1'b1);
      for (int i = 0; i < MAXH; i++) begin
         step(4'b0011, 1'b0);
         check_eq("t5_hold", 32'(bif.grant), 32'b0001);
      end
      step(4'b0011, 1'b0);
      check_eq("t5_tgap", 32'(bif.grant),   32'b0000);
      check_eq("t5_tout", 32'(bif.timeout), 32'd1);
      step(4'b0011, 1'b0);
      check_eq("t5_next", 32'(bif.grant),   32'b0010);
      check_eq("t5_tclr", 32'(bif.timeout), 32'd0);
      step(4'b0000, 1'b1);
      for (int i = 0; i < MAXH; i++) step(4'b0001, 1'b0);
      step(4'b0001, 1'b0);
      check_eq("t5s_tout", 32'(bif.timeout), 32'd1);
      step(4'b0001, 1'b0);
      check_eq("t5s_regrant", 32'(bif.grant), 32'b0001);

      // 6: reset mid-tenure, then random soak
      step(4'b0000, 1'b1);
      step(4'b0100, 1'b0);
      check_eq("t6_pre", 32'(bif.grant), 32'b0100);
      step(4'b0100, 1'b1);
      check_eq("t6_rst", 32'(bif.grant), 32'b0000);

      r = 4'b0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
         step(r, ($urandom_range(0, 63) == 0));
         check_eq("soak_busy", 32'(bif.bus_busy), 32'(|bif.grant));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Hard stop in case the clock or a step ever stalls.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
